// File: rtl/fb_scanout_pkg.sv
// Shared constants and types for the frame-buffer scanout reader.
package fb_scanout_pkg;

  localparam int FRAME_WORDS  = 38400;
  localparam int FRAME_PIXELS = 76800;
  localparam int PIXEL_W      = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/fb_scanout_reader_if.sv
// Memory read port plus pixel stream of the scanout reader.
// master = reader side, slave = memory + video sink side.
interface fb_scanout_reader_if #(
  parameter int ADDR_W = 16
);
  import fb_scanout_pkg::*;

  logic [ADDR_W-1:0]  mem_address;
  logic               mem_chipselect;
  logic               mem_write;
  logic [3:0]         mem_byteenable;
  logic               mem_clken;
  logic [31:0]        mem_readdata;

  logic [PIXEL_W-1:0] px_data;
  logic               px_valid;
  logic               px_ready;
  logic               px_sop;
  logic               px_eop;

  modport master (
    output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    input  mem_readdata,
    output px_data, px_valid, px_sop, px_eop,
    input  px_ready
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
    output mem_readdata,
    input  px_data, px_valid, px_sop, px_eop,
    output px_ready
  );

endinterface

// File: rtl/fb_scanout_fifo.sv
// Synchronous show-ahead word FIFO; rdata always shows the head entry.
module fb_scanout_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  import fb_scanout_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/fb_scanout_reader.sv
// Frame-buffer scanout reader: credit-limited read master feeding a word
// FIFO, unpacked into a 16-bit RGB565 ready/valid stream with sop/eop.
// Optional feature macro: FB_SCANOUT_UNDERFLOW_EN adds underflow_count.
//
//   state | meaning
//   IDLE  | no reads issued
//   RUN   | issuing reads while credit allows
//   DRAIN | whole frame issued; waiting for the eop pixel to be accepted
module fb_scanout_reader #(
  parameter int FRAME_WORDS = fb_scanout_pkg::FRAME_WORDS,
  parameter int ADDR_W      = 16,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  fb_scanout_reader_if.master  bus,
  output logic                 frame_done
`ifdef FB_SCANOUT_UNDERFLOW_EN
  ,
  output logic [15:0]          underflow_count
`endif
);
  import fb_scanout_pkg::*;

  localparam int              CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [16:0]     LAST_PIXEL = 17'(2 * FRAME_WORDS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  state_t             state;
  logic [ADDR_W-1:0]  addr_q;
  logic               cs_q;
  logic               inflight_q;
  logic               half_q;
  logic [16:0]        pix_cnt;
  logic               fifo_pop;
  logic               fifo_empty;
  logic [31:0]        fifo_rdata;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W:0]     occ_nx;
  logic               credit_ok;
  logic               px_valid;
  logic               px_acc;
  logic               eop_acc;
  logic [PIXEL_W-1:0] px_data;

  fb_scanout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_q),
    .pop   (fifo_pop),
    .wdata (bus.mem_readdata),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign px_valid = !fifo_empty;
  assign px_data  = px_valid ? (half_q ? fifo_rdata[31:16] : fifo_rdata[15:0]) : '0;
  assign px_acc   = px_valid & bus.px_ready;
  assign fifo_pop = px_acc & half_q;
  assign eop_acc  = px_acc & (pix_cnt == LAST_PIXEL);

  // Next-cycle count + inflight: chipselect is registered, so the credit
  // test is evaluated one cycle ahead; the read issued now is next cycle's inflight.
  assign occ_nx    = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q)
                   + (CNT_W+1)'(cs_q) - (CNT_W+1)'(fifo_pop);
  assign credit_ok = occ_nx < (CNT_W+1)'(FIFO_DEPTH);

  // Read-issue FSM with registered address and chipselect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      cs_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cs_q <= 1'b0;
          if (enable) begin
            state  <= RUN;
            addr_q <= '0;
            cs_q   <= credit_ok;
          end
        end
        RUN: begin
          if (cs_q) addr_q <= addr_q + 1'b1;
          if (cs_q && addr_q == LAST_ADDR) begin
            state <= DRAIN;
            cs_q  <= 1'b0;
          end else begin
            cs_q <= credit_ok;
          end
        end
        DRAIN: begin
          cs_q <= 1'b0;
          if (eop_acc) begin
            if (enable) begin
              state  <= RUN;
              addr_q <= '0;
              cs_q   <= credit_ok;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          cs_q  <= 1'b0;
        end
      endcase
    end
  end

  // Fixed one-cycle read latency: the returned word is pushed the cycle after issue.
  always_ff @(posedge clk) begin
    if (reset) inflight_q <= 1'b0;
    else       inflight_q <= cs_q;
  end

  // Unpacker half select, pixel counter and frame_done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      half_q     <= 1'b0;
      pix_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= eop_acc;
      if (px_acc) begin
        half_q  <= ~half_q;
        pix_cnt <= eop_acc ? '0 : pix_cnt + 1'b1;
      end
    end
  end

`ifdef FB_SCANOUT_UNDERFLOW_EN
  // Saturating count of cycles the sink waited on an active scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      underflow_count <= '0;
    end else if (px_acc && pix_cnt == '0) begin
      underflow_count <= '0;
    end else if ((state == RUN || state == DRAIN) && bus.px_ready && !px_valid
                 && underflow_count != 16'hFFFF) begin
      underflow_count <= underflow_count + 1'b1;
    end
  end
`endif

  assign bus.mem_address    = addr_q;
  assign bus.mem_chipselect = cs_q;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = 4'hF;
  assign bus.mem_clken      = 1'b1;
  assign bus.px_data        = px_data;
  assign bus.px_valid       = px_valid;
  assign bus.px_sop         = px_valid & (pix_cnt == '0);
  assign bus.px_eop         = px_valid & (pix_cnt == LAST_PIXEL);

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Scoreboard bench for fb_scanout_reader with a small frame (32 words).
module tb_fb_scanout_reader;
  localparam int FW    = 32;
  localparam int LAST  = 2 * FW - 1;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [15:0] d;
    logic        sop;
    logic        eop;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic frame_done;
`ifdef FB_SCANOUT_UNDERFLOW_EN
  logic [15:0] underflow_count;
`endif

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  int   issued = 0, popped = 0, acc_idx = 0, px_accepted = 0, frames = 0;
  logic hold_v = 1'b0, eop_prev = 1'b0;
  logic [15:0] hold_d;

  fb_scanout_reader_if #(.ADDR_W(16)) bus ();

  fb_scanout_reader #(
    .FRAME_WORDS (FW),
    .ADDR_W      (16),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .bus        (bus),
    .frame_done (frame_done)
`ifdef FB_SCANOUT_UNDERFLOW_EN
    ,
    .underflow_count (underflow_count)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: word k = {2k+1, 2k}, valid one cycle after chipselect.
  always @(posedge clk) begin
    if (bus.mem_chipselect)
      bus.mem_readdata <= {16'(2 * bus.mem_address + 1), 16'(2 * bus.mem_address)};
    else
      bus.mem_readdata <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame();
    for (int p = 0; p <= LAST; p++) begin
      exp_t e;
      e.d   = 16'(p);
      e.sop = (p == 0);
      e.eop = (p == LAST);
      sb.push_back(e);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_addr"},  32'(bus.mem_address), 0);
    chk({tag, "_cs"},    32'(bus.mem_chipselect), 0);
    chk({tag, "_valid"}, 32'(bus.px_valid), 0);
    chk({tag, "_sop"},   32'(bus.px_sop), 0);
    chk({tag, "_eop"},   32'(bus.px_eop), 0);
    chk({tag, "_data"},  32'(bus.px_data), 0);
    chk({tag, "_done"},  32'(frame_done), 0);
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_wait", 32'(frames >= target), 1);
  endtask

  // Monitor: credit rule, pixel scoreboard, hold-stable rule, frame_done pulse.
  always @(negedge clk) begin
    if (bus.mem_chipselect === 1'b1) begin
      tests++;
      if (issued - popped >= DEPTH) begin
        fails++;
        $display("FAIL credit: read issued with %0d words buffered/in flight, limit %0d",
                 issued - popped, DEPTH);
      end
      issued++;
    end
    if (hold_v) begin
      tests++;
      if (bus.px_valid !== 1'b1 || bus.px_data !== hold_d) begin
        fails++;
        $display("FAIL hold: valid=%0b data=%0h expected valid=1 data=%0h",
                 bus.px_valid, bus.px_data, hold_d);
      end
    end
    hold_v = (bus.px_valid === 1'b1) && (bus.px_ready === 1'b0);
    hold_d = bus.px_data;
    if (bus.px_valid === 1'b1 && bus.px_ready === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL pixel: unexpected pixel %0h, scoreboard empty", bus.px_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({bus.px_data, bus.px_sop, bus.px_eop} !== e) begin
          fails++;
          $display("FAIL pixel: got data=%0h sop=%0b eop=%0b expected data=%0h sop=%0b eop=%0b",
                   bus.px_data, bus.px_sop, bus.px_eop, e.d, e.sop, e.eop);
        end
      end
      if (acc_idx % 2 == 1) popped++;
      acc_idx = (acc_idx == LAST) ? 0 : acc_idx + 1;
      px_accepted++;
    end
    if (frame_done === 1'b1 || eop_prev) begin
      tests++;
      if (frame_done !== eop_prev) begin
        fails++;
        $display("FAIL frame_done: got %0b expected %0b", frame_done, eop_prev);
      end
    end
    if (frame_done === 1'b1) frames++;
    eop_prev = (bus.px_valid === 1'b1) && (bus.px_ready === 1'b1) && (bus.px_eop === 1'b1);
    if (reset === 1'b1) begin
      issued   = 0;
      popped   = 0;
      acc_idx  = 0;
      hold_v   = 1'b0;
      eop_prev = 1'b0;
    end
  end

  initial begin
    int gap, cnt, n, base;
    bit found;
    reset = 1'b1;
    enable = 1'b0;
    bus.px_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset("por");

    // Start latency, back-to-back frames, enable dropped during frame 2.
    @(posedge clk); #1;
    bus.px_ready = 1'b1;
    enable = 1'b1;
    push_frame();
    push_frame();
    @(negedge clk); chk("c0_cs", 32'(bus.mem_chipselect), 0);
    @(negedge clk); chk("c1_cs", 32'(bus.mem_chipselect), 1);
    chk("c1_addr", 32'(bus.mem_address), 0);
    @(negedge clk); chk("c2_valid", 32'(bus.px_valid), 0);
    @(negedge clk); chk("c3_valid", 32'(bus.px_valid), 1);
    chk("c3_sop", 32'(bus.px_sop), 1);
    chk("c3_data", 32'(bus.px_data), 0);
`ifdef FB_SCANOUT_UNDERFLOW_EN
    chk("c3_underflow", 32'(underflow_count), 2);
`endif
    found = 0;
    n = 0;
    while (!found && n < 300) begin
      @(negedge clk);
      n++;
      found = bus.px_valid && bus.px_ready && bus.px_eop;
    end
    chk("b2b_eop_seen", 32'(found), 1);
    chk("b2b_no_early_read", 32'(bus.mem_chipselect), 0);
    gap = 0;
    found = 0;
    while (!found && gap < 10) begin
      @(negedge clk);
      if (bus.px_valid) found = 1;
      else gap++;
    end
    chk("b2b_gap_le3", 32'(gap <= 3), 1);
    n = 0;
    while (px_accepted < 2 * FW + 10 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    enable = 1'b0;
    wait_frames(2);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.mem_chipselect) cnt++;
    end
    chk("idle_no_reads", 32'(cnt), 0);

    // Random 50% ready.
    @(posedge clk); #1;
    push_frame();
    enable = 1'b1;
    n = 0;
    while (frames < 3 && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (n == 2) enable = 1'b0;
      bus.px_ready = 1'($urandom_range(0, 1));
    end
    bus.px_ready = 1'b1;
    wait_frames(3);

    // Sink stalled for 100 cycles mid-frame.
    @(posedge clk); #1;
    push_frame();
    enable = 1'b1;
    base = px_accepted;
    n = 0;
    while (px_accepted < base + 6 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    enable = 1'b0;
    bus.px_ready = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("stall_buffered", 32'(issued - popped), DEPTH);
    chk("stall_no_read", 32'(bus.mem_chipselect), 0);
    @(posedge clk); #1;
    bus.px_ready = 1'b1;
    wait_frames(4);

    // Reset mid-frame while a read is in flight.
    @(posedge clk); #1;
    push_frame();
    enable = 1'b1;
    base = px_accepted;
    found = 0;
    n = 0;
    while (!found && n < 300) begin
      @(posedge clk); #1;
      n++;
      found = (px_accepted >= base + 20) && bus.mem_chipselect;
    end
    chk("reset_point_found", 32'(found), 1);
    reset = 1'b1;
    enable = 1'b0;
    bus.px_ready = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset("mid_reset");
    repeat (4) @(negedge clk);
    chk("reset_discard", 32'(bus.px_valid), 0);
    @(posedge clk); #1;
    push_frame();
    enable = 1'b1;
    bus.px_ready = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    wait_frames(5);

    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
